// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants for the stopwatch sequencer:
//   - FSM state encoding (2-bit, legacy-compatible localparam constants)
//   - default prescaler division ratio and width (50 MHz -> 100 Hz tick)
// Optional build macro used by the sequencer: STOPWATCH_OVF_STOP_EN
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAP  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam int unsigned DIV_DEFAULT  = 32'd500000;
    localparam int unsigned DIVW_DEFAULT = 32'd19;

endpackage : stopwatch_pkg

// File: rtl/sw_key_edge.sv
// -----------------------------------------------------------------------------
// sw_key_edge
// Conditions one asynchronous key: two-flop synchroniser, then a delay flop,
// producing a single-cycle pulse on each rising edge of the synchronised key.
// A held key therefore yields exactly one press.
// Ports:
//   clk    in  system clock
//   nclr   in  asynchronous active-low reset
//   key_in in  raw key level (active high, asynchronous to clk)
//   press  out one-cycle rising-edge pulse (combinational from flops)
// -----------------------------------------------------------------------------
module sw_key_edge (
    input  logic clk,
    input  logic nclr,
    input  logic key_in,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Synchroniser chain plus one delay stage for edge detection
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign press = sync2_q & ~dly_q;

endmodule : sw_key_edge

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencer between the DE0 keys and the stopwatch digit-counter chain.
// IDLE/RUN/LAP/STOP state machine driven by start/stop, lap and clear keys,
// a prescaler producing the 1/100 s count-enable tick, a one-cycle active-low
// clear for the counter chain and a lap-hold (display freeze) flag.
// Optional build macro: STOPWATCH_OVF_STOP_EN -- adds input at_max; a tick due
// while the chain is at full scale is suppressed and the watch stops there.
// Ports:
//   clk       in  system clock
//   nclr      in  asynchronous active-low reset
//   btn_ss    in  start/stop key (async level)
//   btn_lap   in  lap key (async level)
//   btn_clr   in  clear key (async level)
//   at_max    in  all digits at max (only with STOPWATCH_OVF_STOP_EN)
//   cnt_en    out registered one-cycle tick to counter-chain cin
//   cnt_clr_n out registered one-cycle active-low clear
//   lap_hold  out high in LAP
//   running   out high in RUN or LAP
//   state     out current FSM state
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV  = DIV_DEFAULT,
    parameter int unsigned DIVW = DIVW_DEFAULT
) (
    input  logic       clk,
    input  logic       nclr,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
`ifdef STOPWATCH_OVF_STOP_EN
    input  logic       at_max,
`endif
    output logic       cnt_en,
    output logic       cnt_clr_n,
    output logic       lap_hold,
    output logic       running,
    output logic [1:0] state
);

    localparam logic [DIVW-1:0] PRE_LAST = DIVW'(DIV - 32'd1);

    logic            press_ss_s, press_lap_s, press_clr_s;
    logic            sel_ss_s, sel_lap_s, sel_clr_s;
    logic            at_max_s, run_s, tick_s, ovf_s, clr_s;
    logic [1:0]      state_d, state_q;
    logic [DIVW-1:0] pre_d, pre_q;
    logic            cnt_en_d, cnt_en_q;
    logic            cnt_clr_n_d, cnt_clr_n_q;
    logic            lap_hold_d, lap_hold_q;
    logic            running_d, running_q;

    sw_key_edge u_key_ss  (.clk(clk), .nclr(nclr), .key_in(btn_ss),  .press(press_ss_s));
    sw_key_edge u_key_lap (.clk(clk), .nclr(nclr), .key_in(btn_lap), .press(press_lap_s));
    sw_key_edge u_key_clr (.clk(clk), .nclr(nclr), .key_in(btn_clr), .press(press_clr_s));

`ifdef STOPWATCH_OVF_STOP_EN
    assign at_max_s = at_max;
`else
    assign at_max_s = 1'b0;
`endif

    // Only the highest-priority press of a cycle survives; it may still be
    // ignored by the current state, in which case nothing happens.
    assign sel_clr_s = press_clr_s;
    assign sel_ss_s  = press_ss_s & ~press_clr_s;
    assign sel_lap_s = press_lap_s & ~press_ss_s & ~press_clr_s;

    // Counting is decided from the pre-transition state, so a tick due on a
    // RUN->STOP edge is still issued.
    assign run_s  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick_s = run_s && (pre_q == PRE_LAST);
    assign ovf_s  = tick_s & at_max_s;

    // Next-state and clear decode
    always_comb begin
        state_d = state_q;
        clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_clr_s) begin
                    clr_s = 1'b1;
                end else if (sel_ss_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ovf_s || sel_ss_s) begin
                    state_d = ST_STOP;
                end else if (sel_lap_s) begin
                    state_d = ST_LAP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (ovf_s || sel_ss_s) begin
                    state_d = ST_STOP;
                end else if (sel_lap_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LAP;
                end
            end
            ST_STOP: begin
                if (sel_clr_s) begin
                    state_d = ST_IDLE;
                    clr_s   = 1'b1;
                end else if (sel_ss_s && !at_max_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler next value and registered output decode
    always_comb begin
        pre_d = pre_q;
        if (clr_s || tick_s) begin
            pre_d = '0;
        end else if (run_s) begin
            pre_d = pre_q + DIVW'(1);
        end else begin
            pre_d = pre_q;
        end
        cnt_en_d    = tick_s & ~at_max_s;
        cnt_clr_n_d = ~clr_s;
        lap_hold_d  = (state_d == ST_LAP);
        running_d   = (state_d == ST_RUN) || (state_d == ST_LAP);
    end

    // State, prescaler and output registers
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_n_q <= 1'b1;
            lap_hold_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_n_q <= cnt_clr_n_d;
            lap_hold_q  <= lap_hold_d;
            running_q   <= running_d;
        end
    end

    assign state     = state_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_clr_n = cnt_clr_n_q;
    assign lap_hold  = lap_hold_q;
    assign running   = running_q;

endmodule : stopwatch_ctrl

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencer for the stopwatch digit-counter chain.
- Turns start/stop, lap and clear key inputs into a Run/Stop/Lap/Idle state machine.
- Generates the 1/100 s count-enable pulse (cin of the least-significant digit counter), a one-cycle active-low clear for the counter chain, and a lap-hold (display freeze) flag.
- Sits between the DE0 key inputs and the digit-counter chain / display latch.

Parameters:
- DIV, 500000, clocks per count tick (50 MHz / 500000 = 100 Hz); legal range 2..2^DIVW.
- DIVW, 19, prescaler width; must satisfy 2^DIVW >= DIV.

Ports:
- clk  in  1  system clock; all logic on posedge.
- nclr  in  1  asynchronous active-low reset.
- btn_ss  in  1  start/stop key, active-high level, asynchronous to clk.
- btn_lap  in  1  lap key, active-high level, asynchronous to clk.
- btn_clr  in  1  clear key, active-high level, asynchronous to clk.
- cnt_en  out  1  registered one-cycle tick pulse to the counter-chain cin.
- cnt_clr_n  out  1  registered active-low clear to the counter-chain nclr; low for exactly one cycle.
- lap_hold  out  1  high while the display is frozen (state LAP).
- running  out  1  high in RUN or LAP (run LED).
- state  out  2  current FSM state (encoding in package).

Behaviour:
- Reset (nclr=0, asynchronous, takes effect immediately, also mid-count):
  - state=IDLE, cnt_en=0, cnt_clr_n=1, lap_hold=0, running=0.
  - Prescaler=0; all synchroniser and edge flops=0.
- Key conditioning, per key:
  - 2-flop synchroniser followed by a delay flop.
  - press = sync2 & ~delay: a one-cycle rising-edge pulse.
  - Holding a key generates exactly one press.
  - A key high at the first clock edge sampled high causes the state update on the 3rd clock edge after it.
- Presses in the same cycle: priority clr > ss > lap; lower-priority presses are discarded, not queued.
- State transitions; any press not listed is ignored:
  - IDLE: ss -> RUN. clr -> IDLE and asserts clear.
  - RUN: ss -> STOP. lap -> LAP. clr ignored.
  - LAP: lap -> RUN. ss -> STOP. clr ignored.
  - STOP: ss -> RUN. clr -> IDLE and asserts clear.
- Clear:
  - cnt_clr_n is driven 0 on the clock edge that performs the accepted clr transition.
  - It returns to 1 on the next edge.
  - The same clear zeroes the prescaler.
- Prescaler:
  - Counts 0..DIV-1 only while running=1.
  - Holds its value in STOP and IDLE, so a stop/restart keeps the partial tick.
  - When the prescaler equals DIV-1 and running=1: the prescaler wraps to 0 and cnt_en=1 on the next cycle.
  - First tick after IDLE->RUN: cnt_en is high on the DIV-th clock after the state becomes RUN.
- A tick due on the same edge as RUN->STOP is still issued, because the count is decided from the pre-transition state.
- lap_hold = (state==LAP); running = (state==RUN || state==LAP). Both are registered, with no extra latency beyond state.
- cnt_en is never high while cnt_clr_n=0.

Optional Feature:
- Macro: STOPWATCH_OVF_STOP_EN.
- Defined:
  - Adds input port at_max (1 bit, level): high when every digit counter is at its maxcnt.
  - A tick due while at_max=1 is suppressed (cnt_en stays 0), the prescaler wraps, and state goes to STOP. The display stays at full scale.
  - A subsequent ss press from this STOP is ignored while at_max=1; only clr leaves.
- Undefined:
  - No at_max port; the counter chain wraps to zero naturally.

Decomposition:
- Package stopwatch_pkg:
  - State encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_LAP=2'd2, ST_STOP=2'd3.
  - Default DIV constant and DIVW.
- Sub-module sw_key_edge: synchroniser plus rising-edge detector (clk, nclr, key_in, press). Instantiated three times.
- Prescaler and FSM stay inline.

Test Plan (DIV=4 unless stated):
- Reset: nclr low mid-RUN with prescaler=2 -> all outputs go to reset values immediately; after release, state=IDLE and no cnt_en for 20 clocks.
- Start/tick cadence: one ss press -> state=RUN 3 edges later; cnt_en pulses exactly every 4 clocks; 10 pulses in 40 clocks; first pulse on the 4th clock in RUN.
- Stop/resume: stop when prescaler=2, wait 10 clocks, resume -> no cnt_en while stopped; first tick 2 clocks after resume.
- Lap:
  - In RUN, lap press -> lap_hold=1, running=1, cnt_en continues.
  - Second lap press -> lap_hold=0.
  - ss from LAP -> STOP with lap_hold=0.
- Clear/priority:
  - In STOP, ss+clr pressed together -> IDLE, cnt_clr_n low exactly 1 cycle, prescaler=0.
  - clr in RUN -> ignored, cnt_clr_n stays 1.
  - Key held 100 clocks -> single transition.
- Overflow (STOPWATCH_OVF_STOP_EN): at_max=1 in RUN -> next due tick suppressed, state=STOP; ss ignored; clr -> IDLE with clear pulse.
